// File: rtl/psk_pkg.sv
// Shared constants for the PSK demodulator: symbol geometry, QPSK Gray map,
// datapath width helpers and output-register state encoding.
package psk_pkg;

    localparam int SYM_LEN = 16;

    localparam logic [1:0] QPSK_P1 = 2'b00;
    localparam logic [1:0] QPSK_MJ = 2'b10;
    localparam logic [1:0] QPSK_M1 = 2'b11;
    localparam logic [1:0] QPSK_PJ = 2'b01;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic int prod_width(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int acc_width(input int w);
        return 2 * w + 5;
    endfunction

    // Quadrant decision from the signs of (re+im) and (re-im).
    function automatic logic [1:0] qpsk_map(input logic neg_sum, input logic neg_diff);
        logic [1:0] sym;
        case ({neg_sum, neg_diff})
            2'b00:   sym = QPSK_P1;
            2'b10:   sym = QPSK_MJ;
            2'b11:   sym = QPSK_M1;
            2'b01:   sym = QPSK_PJ;
            default: sym = QPSK_P1;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/psk_sym_acc.sv
// Symbol-window correlator: window counter/alignment, complex product with the
// carrier, and per-window accumulation with sideband capture.
module psk_sym_acc
    import psk_pkg::*;
#(
    parameter int WIDTH = 12,
    localparam int AW = acc_width(WIDTH)
) (
    input  logic                    clk_16M384,
    input  logic                    rst_n_16M384,
    input  logic signed [WIDTH-1:0] i_in_i,
    input  logic signed [WIDTH-1:0] i_in_q,
    input  logic signed [WIDTH-1:0] i_car_i,
    input  logic signed [WIDTH-1:0] i_car_q,
    input  logic                    i_vld,
    input  logic                    i_last,
    input  logic                    i_bpsk,
    input  logic [3:0]              i_delay_cnt,
    output logic                    o_clk_div,
    output logic signed [AW-1:0]    o_acc_re,
    output logic signed [AW-1:0]    o_acc_im,
    output logic                    o_done,
    output logic                    o_vld,
    output logic                    o_bpsk,
    output logic                    o_last
);

    localparam int PW = prod_width(WIDTH);
    localparam int XW = 2 * WIDTH;
    localparam logic [3:0] P_FIRST = 4'd0;
    localparam logic [3:0] P_LAST  = 4'(SYM_LEN - 1);

    logic [3:0] r_cnt;
    logic [3:0] r_delay;
    logic       r_win;
    logic       r_vld;
    logic       r_bpsk;
    logic       r_last;

    logic signed [PW-1:0] r_re_p;
    logic signed [PW-1:0] r_im_p;
    logic                 r_load;
    logic                 r_end;
    logic                 r_s1_vld;
    logic                 r_s1_bpsk;
    logic                 r_s1_last;

    logic signed [AW-1:0] r_acc_re;
    logic signed [AW-1:0] r_acc_im;
    logic                 r_done;
    logic                 r_s2_vld;
    logic                 r_s2_bpsk;
    logic                 r_s2_last;

    logic [3:0]           w_delay;
    logic [3:0]           w_p;
    logic                 w_start;
    logic                 w_end;
    logic signed [XW-1:0] w_in_i_x;
    logic signed [XW-1:0] w_in_q_x;
    logic signed [XW-1:0] w_car_i_x;
    logic signed [XW-1:0] w_car_q_x;
    logic signed [XW-1:0] w_ii;
    logic signed [XW-1:0] w_qq;
    logic signed [XW-1:0] w_qi;
    logic signed [XW-1:0] w_iq;
    logic signed [PW-1:0] w_re_p;
    logic signed [PW-1:0] w_im_p;

    // Outside a window the live DELAY_CNT steers alignment; inside, the value captured at p=0 holds.
    assign w_delay = r_win ? r_delay : i_delay_cnt;
    assign w_p     = r_cnt - w_delay;
    assign w_start = !r_win && (w_p == P_FIRST);
    assign w_end   = r_win && (w_p == P_LAST);

    assign w_in_i_x  = {{WIDTH{i_in_i[WIDTH-1]}}, i_in_i};
    assign w_in_q_x  = {{WIDTH{i_in_q[WIDTH-1]}}, i_in_q};
    assign w_car_i_x = {{WIDTH{i_car_i[WIDTH-1]}}, i_car_i};
    assign w_car_q_x = {{WIDTH{i_car_q[WIDTH-1]}}, i_car_q};
    assign w_ii      = w_in_i_x * w_car_i_x;
    assign w_qq      = w_in_q_x * w_car_q_x;
    assign w_qi      = w_in_q_x * w_car_i_x;
    assign w_iq      = w_in_i_x * w_car_q_x;
    assign w_re_p    = {w_ii[XW-1], w_ii} + {w_qq[XW-1], w_qq};
    assign w_im_p    = {w_qi[XW-1], w_qi} - {w_iq[XW-1], w_iq};

    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            r_cnt   <= 4'd0;
            r_delay <= 4'd0;
            r_win   <= 1'b0;
            r_vld   <= 1'b0;
            r_bpsk  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
            if (w_start) begin
                r_win   <= 1'b1;
                r_delay <= i_delay_cnt;
                r_vld   <= i_vld;
                r_bpsk  <= i_bpsk;
                r_last  <= i_last;
            end else begin
                if (w_end) begin
                    r_win <= 1'b0;
                end
                r_last <= r_last | i_last;
            end
        end
    end

    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            r_re_p    <= '0;
            r_im_p    <= '0;
            r_load    <= 1'b0;
            r_end     <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_bpsk <= 1'b0;
            r_s1_last <= 1'b0;
        end else begin
            r_re_p    <= w_re_p;
            r_im_p    <= w_im_p;
            r_load    <= w_start;
            r_end     <= w_end;
            r_s1_vld  <= r_vld;
            r_s1_bpsk <= r_bpsk;
            r_s1_last <= r_last | i_last;
        end
    end

    // The p=0 product reloads the accumulators so stale sums never leak into a new window.
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_done    <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_bpsk <= 1'b0;
            r_s2_last <= 1'b0;
        end else begin
            if (r_load) begin
                r_acc_re <= {{(AW-PW){r_re_p[PW-1]}}, r_re_p};
                r_acc_im <= {{(AW-PW){r_im_p[PW-1]}}, r_im_p};
            end else begin
                r_acc_re <= r_acc_re + {{(AW-PW){r_re_p[PW-1]}}, r_re_p};
                r_acc_im <= r_acc_im + {{(AW-PW){r_im_p[PW-1]}}, r_im_p};
            end
            r_done    <= r_end;
            r_s2_vld  <= r_s1_vld;
            r_s2_bpsk <= r_s1_bpsk;
            r_s2_last <= r_s1_last;
        end
    end

    assign o_clk_div = r_cnt[3];
    assign o_acc_re  = r_acc_re;
    assign o_acc_im  = r_acc_im;
    assign o_done    = r_done;
    assign o_vld     = r_s2_vld;
    assign o_bpsk    = r_s2_bpsk;
    assign o_last    = r_s2_last;

endmodule

// File: rtl/psk_demod.sv
// Coherent BPSK/QPSK demodulator: 16-sample correlation, sign decision and a
// single-entry AXI-Stream output register with sticky overflow.
module psk_demod
    import psk_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int BYTES = 1
) (
    input  logic                    clk_16M384,
    input  logic                    rst_n_16M384,
    input  logic signed [WIDTH-1:0] in_I,
    input  logic signed [WIDTH-1:0] in_Q,
    input  logic                    in_vld,
    input  logic                    in_last,
    input  logic                    in_is_bpsk,
    input  logic signed [WIDTH-1:0] carrier_I,
    input  logic signed [WIDTH-1:0] carrier_Q,
    input  logic [3:0]              DELAY_CNT,
    output logic [BYTES*8-1:0]      m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    m_tuser,
    output logic                    overflow,
    output logic                    out_clk_1M024
);

    localparam int AW = acc_width(WIDTH);
    localparam int DW = BYTES * 8;
    localparam logic signed [AW-1:0] ZERO_ACC = '0;
    localparam logic signed [AW:0]   ZERO_SUM = '0;

    logic signed [AW-1:0] w_acc_re;
    logic signed [AW-1:0] w_acc_im;
    logic                 w_done;
    logic                 w_vld;
    logic                 w_bpsk;
    logic                 w_last;
    logic signed [AW:0]   w_sum;
    logic signed [AW:0]   w_diff;
    logic [1:0]           w_bits;
    logic                 w_hs;

    logic          r_dec_vld;
    logic [1:0]    r_dec_bits;
    logic          r_dec_bpsk;
    logic          r_dec_last;
    logic [0:0]    r_state;
    logic [DW-1:0] r_tdata;
    logic          r_tlast;
    logic          r_tuser;
    logic          r_overflow;

    psk_sym_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk_16M384   (clk_16M384),
        .rst_n_16M384 (rst_n_16M384),
        .i_in_i       (in_I),
        .i_in_q       (in_Q),
        .i_car_i      (carrier_I),
        .i_car_q      (carrier_Q),
        .i_vld        (in_vld),
        .i_last       (in_last),
        .i_bpsk       (in_is_bpsk),
        .i_delay_cnt  (DELAY_CNT),
        .o_clk_div    (out_clk_1M024),
        .o_acc_re     (w_acc_re),
        .o_acc_im     (w_acc_im),
        .o_done       (w_done),
        .o_vld        (w_vld),
        .o_bpsk       (w_bpsk),
        .o_last       (w_last)
    );

    assign w_sum  = {w_acc_re[AW-1], w_acc_re} + {w_acc_im[AW-1], w_acc_im};
    assign w_diff = {w_acc_re[AW-1], w_acc_re} - {w_acc_im[AW-1], w_acc_im};

    // A zero sum counts as non-negative and decides to bit 0.
    always_comb begin
        w_bits = 2'b00;
        if (w_bpsk) begin
            w_bits = {(w_acc_re < ZERO_ACC), 1'b0};
        end else begin
            w_bits = qpsk_map((w_sum < ZERO_SUM), (w_diff < ZERO_SUM));
        end
    end

    assign w_hs = (r_state == ST_FULL) && m_tready;

    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            r_dec_vld  <= 1'b0;
            r_dec_bits <= 2'b00;
            r_dec_bpsk <= 1'b0;
            r_dec_last <= 1'b0;
        end else begin
            r_dec_vld  <= w_done && w_vld;
            r_dec_bits <= w_bits;
            r_dec_bpsk <= w_bpsk;
            r_dec_last <= w_last;
        end
    end

    // A decision arriving while FULL and not handshaking is dropped; the held beat stays intact.
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            r_state    <= ST_EMPTY;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (r_dec_vld) begin
                if ((r_state == ST_EMPTY) || w_hs) begin
                    r_state <= ST_FULL;
                    r_tdata <= {{(DW-2){1'b0}}, r_dec_bits};
                    r_tlast <= r_dec_last;
                    r_tuser <= r_dec_bpsk;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_hs) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign m_tvalid = (r_state == ST_FULL);
    assign m_tdata  = r_tdata;
    assign m_tlast  = r_tlast;
    assign m_tuser  = r_tuser;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_psk_demod.sv
// Self-checking bench for psk_demod: directed symbol windows plus random traffic,
// compared cycle by cycle against a window-level behavioural model.
module tb_psk_demod;

    localparam int WIDTH = 12;
    localparam int BYTES = 1;

    logic                    clk_16M384 = 1'b0;
    logic                    rst_n_16M384;
    logic signed [WIDTH-1:0] in_I;
    logic signed [WIDTH-1:0] in_Q;
    logic                    in_vld;
    logic                    in_last;
    logic                    in_is_bpsk;
    logic signed [WIDTH-1:0] carrier_I;
    logic signed [WIDTH-1:0] carrier_Q;
    logic [3:0]              DELAY_CNT;
    logic [BYTES*8-1:0]      m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;
    logic                    m_tuser;
    logic                    overflow;
    logic                    out_clk_1M024;

    psk_demod #(.WIDTH(WIDTH), .BYTES(BYTES)) dut (
        .clk_16M384    (clk_16M384),
        .rst_n_16M384  (rst_n_16M384),
        .in_I          (in_I),
        .in_Q          (in_Q),
        .in_vld        (in_vld),
        .in_last       (in_last),
        .in_is_bpsk    (in_is_bpsk),
        .carrier_I     (carrier_I),
        .carrier_Q     (carrier_Q),
        .DELAY_CNT     (DELAY_CNT),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .overflow      (overflow),
        .out_clk_1M024 (out_clk_1M024)
    );

    always #5 clk_16M384 = ~clk_16M384;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: windows are summed with plain integers, decided symbols
    // are scheduled for the output slot three edges after the closing sample.
    typedef struct {
        int         due;
        logic [1:0] bits;
        bit         bpsk;
        bit         last;
    } dec_t;

    typedef struct {
        logic [7:0] d;
        bit         u;
        bit         l;
    } beat_t;

    int         m_cnt;
    int         m_edge;
    bit         m_open;
    int         m_align;
    int         m_sre;
    int         m_sim;
    bit         m_vld;
    bit         m_bpsk;
    bit         m_wlast;
    dec_t       m_q[$];
    bit         m_full;
    logic [1:0] m_bits;
    bit         m_user;
    bit         m_last;
    bit         m_ovf;
    beat_t      got_q[$];

    task automatic model_reset();
        m_cnt  = 0;
        m_edge = 0;
        m_open = 1'b0;
        m_q.delete();
        m_full = 1'b0;
        m_bits = 2'b00;
        m_user = 1'b0;
        m_last = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        bit   hs;
        bit   dec_now;
        dec_t d;
        int   pr;
        int   pi;
        int   align;
        int   p;
        hs      = m_full && m_tready;
        dec_now = 1'b0;
        if (m_q.size() > 0 && m_q[0].due == m_edge) begin
            d       = m_q.pop_front();
            dec_now = 1'b1;
        end
        if (dec_now) begin
            if (!m_full || hs) begin
                m_full = 1'b1;
                m_bits = d.bits;
                m_user = d.bpsk;
                m_last = d.last;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (hs) begin
            m_full = 1'b0;
        end

        pr    = int'(in_I) * int'(carrier_I) + int'(in_Q) * int'(carrier_Q);
        pi    = int'(in_Q) * int'(carrier_I) - int'(in_I) * int'(carrier_Q);
        align = m_open ? m_align : int'(DELAY_CNT);
        p     = (m_cnt - align) & 15;
        if (!m_open && p == 0) begin
            m_open  = 1'b1;
            m_align = int'(DELAY_CNT);
            m_sre   = pr;
            m_sim   = pi;
            m_vld   = in_vld;
            m_bpsk  = in_is_bpsk;
            m_wlast = in_last;
        end else if (m_open) begin
            m_sre   += pr;
            m_sim   += pi;
            m_wlast = m_wlast | in_last;
            if (p == 15) begin
                m_open = 1'b0;
                if (m_vld) begin
                    d.due  = m_edge + 3;
                    d.bpsk = m_bpsk;
                    d.last = m_wlast;
                    if (m_bpsk) d.bits = {m_sre < 0, 1'b0};
                    else        d.bits = {(m_sre + m_sim) < 0, (m_sre - m_sim) < 0};
                    m_q.push_back(d);
                end
            end
        end
        m_cnt  = (m_cnt + 1) % 16;
        m_edge++;
    endtask

    task automatic tick();
        beat_t b;
        if (m_tvalid && m_tready) begin
            b.d = m_tdata;
            b.u = m_tuser;
            b.l = m_tlast;
            got_q.push_back(b);
        end
        @(posedge clk_16M384);
        model_edge();
        @(negedge clk_16M384);
        check_eq("tvalid", 32'(m_tvalid), 32'(m_full));
        if (m_full) begin
            check_eq("tdata", 32'(m_tdata), 32'({6'b000000, m_bits}));
            check_eq("tuser", 32'(m_tuser), 32'(m_user));
            check_eq("tlast", 32'(m_tlast), 32'(m_last));
        end
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("out_clk", 32'(out_clk_1M024), 32'(m_cnt >= 8));
    endtask

    task automatic drive_win(input int i_val, input int q_val, input bit bpsk, input bit vld, input int last_p);
        for (int p = 0; p < 16; p++) begin
            in_I       = 12'(i_val);
            in_Q       = 12'(q_val);
            in_is_bpsk = bpsk;
            in_vld     = vld;
            in_last    = (p == last_p);
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check_eq({tag, "_tdata"}, 32'(m_tdata), 32'd0);
        check_eq({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        check_eq({tag, "_tuser"}, 32'(m_tuser), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    logic [7:0] exp_d[6] = '{8'h00, 8'h02, 8'h03, 8'h01, 8'h02, 8'h00};
    bit         exp_u[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit         exp_l[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n_16M384 = 1'b1;
        in_I = '0; in_Q = '0; in_vld = 1'b0; in_last = 1'b0; in_is_bpsk = 1'b0;
        carrier_I = 12'sd1000; carrier_Q = 12'sd0;
        DELAY_CNT = 4'd0;
        m_tready  = 1'b1;
        model_reset();
        #2 rst_n_16M384 = 1'b0;
        #1 check_reset_outputs("rst0");
        @(negedge clk_16M384);
        @(negedge clk_16M384);
        rst_n_16M384 = 1'b1;

        drive_win(1000, 0, 1'b0, 1'b1, -1);
        drive_win(0, -1000, 1'b0, 1'b1, -1);
        drive_win(-1000, 0, 1'b0, 1'b1, -1);
        drive_win(0, 1000, 1'b0, 1'b1, -1);
        drive_win(-1000, 0, 1'b1, 1'b1, 9);
        drive_win(1000, 0, 1'b0, 1'b0, -1);
        drive_win(0, 0, 1'b0, 1'b1, -1);
        drive_win(0, 0, 1'b0, 1'b0, -1);
        check_eq("dir_beats", 32'(got_q.size()), 32'd6);
        if (got_q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check_eq($sformatf("dir_d%0d", k), 32'(got_q[k].d), 32'(exp_d[k]));
                check_eq($sformatf("dir_u%0d", k), 32'(got_q[k].u), 32'(exp_u[k]));
                check_eq($sformatf("dir_l%0d", k), 32'(got_q[k].l), 32'(exp_l[k]));
            end
        end

        got_q.delete();
        m_tready = 1'b0;
        drive_win(0, 1000, 1'b0, 1'b1, -1);
        drive_win(-1000, 0, 1'b0, 1'b1, -1);
        drive_win(0, 0, 1'b0, 1'b0, -1);
        check_eq("ovf_hold_v", 32'(m_tvalid), 32'd1);
        check_eq("ovf_hold_d", 32'(m_tdata), 32'h01);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        m_tready = 1'b1;
        drive_win(0, 0, 1'b0, 1'b0, -1);
        check_eq("ovf_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check_eq("ovf_first", 32'(got_q[0].d), 32'h01);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        for (int p = 0; p < 7; p++) begin
            in_I = 12'sd1000; in_Q = 12'sd0; in_vld = 1'b1; in_is_bpsk = 1'b0; in_last = 1'b0;
            tick();
        end
        rst_n_16M384 = 1'b0;
        #1 check_reset_outputs("rst7");
        model_reset();
        got_q.delete();
        DELAY_CNT = 4'd5;
        @(negedge clk_16M384);
        @(negedge clk_16M384);
        rst_n_16M384 = 1'b1;
        in_I = 12'sd0; in_Q = -12'sd1000; in_vld = 1'b1;
        for (int k = 0; k < 23; k++) tick();
        check_eq("dly5_early", 32'(m_tvalid), 32'd0);
        tick();
        check_eq("dly5_valid", 32'(m_tvalid), 32'd1);
        check_eq("dly5_data", 32'(m_tdata), 32'h02);

        for (int k = 0; k < 1200; k++) begin
            in_I       = 12'($urandom_range(0, 4095));
            in_Q       = 12'($urandom_range(0, 4095));
            carrier_I  = 12'($urandom_range(0, 4095));
            carrier_Q  = 12'($urandom_range(0, 4095));
            in_vld     = ($urandom_range(0, 7) != 0);
            in_last    = ($urandom_range(0, 9) == 0);
            in_is_bpsk = $urandom_range(0, 1) != 0;
            m_tready   = (k % 300 < 260) ? ($urandom_range(0, 3) != 0) : 1'b0;
            if (k % 53 == 0) DELAY_CNT = 4'($urandom_range(0, 15));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
